// File: rtl/led_blink_sequencer_if.sv
// led_blink_sequencer_if: request/grant and LED bus between status sources and the blink sequencer
// master: drives main_program, req, code; observes grant, done, busy, led
// slave : the sequencer side
interface led_blink_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic                   main_program;
  logic [NUM_REQ-1:0]     req;
  logic [4*NUM_REQ-1:0]   code;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic                   busy;
  logic                   led;
  modport master (output main_program, req, code, input grant, done, busy, led);
  modport slave  (input main_program, req, code, output grant, done, busy, led);
endinterface

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer: round-robin shares one status LED, playing an N-pulse blink code per requester
// clk, rst          : system clock, asynchronous active-high reset
// bus.main_program  : global enable, low aborts to idle
// bus.req/code      : per-requester level request and 4-bit blink count
// bus.grant/done    : one-hot grant held through the code, one-cycle done pulse at the end
// bus.busy/led      : sequencer active, registered LED drive
module led_blink_sequencer #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int TICK_HZ    = 10,
  parameter int NUM_REQ    = 4,
  parameter int ON_TICKS   = 2,
  parameter int OFF_TICKS  = 3,
  parameter int GAP_TICKS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  led_blink_sequencer_if.slave  bus
);
  localparam int DIV  = CLOCK_FREQ / TICK_HZ;
  localparam int PW   = DIV > 1 ? $clog2(DIV) : 1;
  localparam int MAXT = ON_TICKS > OFF_TICKS ? (ON_TICKS > GAP_TICKS ? ON_TICKS : GAP_TICKS)
                                             : (OFF_TICKS > GAP_TICKS ? OFF_TICKS : GAP_TICKS);
  localparam int CW   = $clog2(MAXT + 1);
  localparam int RW   = $clog2(NUM_REQ);
  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_ON   = 2'd1;
  localparam logic [1:0]    S_OFF  = 2'd2;
  localparam logic [1:0]    S_GAP  = 2'd3;
  localparam logic [PW-1:0] PRE_L  = PW'(DIV - 1);
  localparam logic [CW-1:0] ON_L   = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_L  = CW'(OFF_TICKS - 1);
  localparam logic [CW-1:0] GAP_L  = CW'(GAP_TICKS - 1);

  logic [1:0]         r_state;
  logic [PW-1:0]      r_pre;
  logic [CW-1:0]      r_phase;
  logic [3:0]         r_cnt;
  logic [RW-1:0]      r_rr;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_led;
  logic               w_found;
  logic [RW-1:0]      w_win;
  logic [3:0]         w_code;
  logic               w_tick;
  logic               w_last;

  // Scan from the farthest candidate back to rr+1 so the nearest set bit after rr is kept
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(r_rr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = RW'((int'(r_rr) + k) % NUM_REQ);
      end
    end
  end

  assign w_code = bus.code[{w_win, 2'b00} +: 4];
  assign w_tick = r_pre == PRE_L;
  assign w_last = w_tick && r_phase == (r_state == S_ON ? ON_L : r_state == S_OFF ? OFF_L : GAP_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_phase <= '0;
      r_cnt   <= '0;
      r_rr    <= RW'(NUM_REQ - 1);
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_done <= '0;
      if (!bus.main_program) begin
        r_state <= S_IDLE;
        r_pre   <= '0;
        r_phase <= '0;
        r_cnt   <= '0;
        r_grant <= '0;
        r_busy  <= 1'b0;
        r_led   <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (w_found) begin
          r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          r_rr    <= w_win;
          r_cnt   <= w_code;
          r_busy  <= 1'b1;
          r_pre   <= '0;
          r_phase <= '0;
          r_state <= w_code != 4'd0 ? S_ON : S_GAP;
          r_led   <= w_code != 4'd0;
        end
      end else if (w_last) begin
        r_pre   <= '0;
        r_phase <= '0;
        case (r_state)
          S_ON: begin
            r_cnt   <= r_cnt - 4'd1;
            r_led   <= 1'b0;
            r_state <= r_cnt > 4'd1 ? S_OFF : S_GAP;
          end
          S_OFF: begin
            r_led   <= 1'b1;
            r_state <= S_ON;
          end
          default: begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end else begin
        r_pre   <= w_tick ? '0 : r_pre + 1'b1;
        r_phase <= w_tick ? r_phase + 1'b1 : r_phase;
      end
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.led   = r_led;
endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb_led_blink_sequencer: randomized and directed checks of the blink sequencer against a timeline model
module tb_led_blink_sequencer;
  localparam int DIV   = 10;
  localparam int ON_C  = 2 * DIV;
  localparam int OFF_C = 3 * DIV;
  localparam int GAP_C = 10 * DIV;
  localparam int N     = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic       c_led[N], e_led[N], c_busy[N], e_busy[N];
  logic [3:0] c_grant[N], e_grant[N], c_done[N], e_done[N];

  led_blink_sequencer_if #(.NUM_REQ(4)) bus();

  led_blink_sequencer #(
    .CLOCK_FREQ(100), .TICK_HZ(10), .NUM_REQ(4), .ON_TICKS(2), .OFF_TICKS(3), .GAP_TICKS(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle, index 0 = first cycle the grant is visible; req and code held constant
  task automatic model(input logic [3:0] mask, input logic [15:0] cd, input bit one_shot, input int len, input int rr0);
    int t, rr, w, n, d;
    t = 0;
    rr = rr0;
    for (int k = 0; k < len; k++) begin
      e_led[k] = 0; e_busy[k] = 0; e_grant[k] = 0; e_done[k] = 0;
    end
    while (t < len) begin
      w = -1;
      for (int s = 1; s <= 4; s++) if (w < 0 && mask[(rr + s) % 4]) w = (rr + s) % 4;
      n = int'(cd[4*w +: 4]);
      d = n * ON_C + (n > 0 ? n - 1 : 0) * OFF_C + GAP_C;
      for (int k = 0; k < d && t + k < len; k++) begin
        e_grant[t+k] = 4'(1 << w);
        e_busy[t+k]  = 1'b1;
        e_led[t+k]   = (k / (ON_C + OFF_C) < n) && (k % (ON_C + OFF_C) < ON_C);
      end
      if (t + d < len) e_done[t+d] = 4'(1 << w);
      rr = w;
      t += d + 1;
      if (one_shot) break;
    end
  endtask

  task automatic capture(input int from, input int to);
    for (int k = from; k < to; k++) begin
      c_led[k] = bus.led; c_busy[k] = bus.busy; c_grant[k] = bus.grant; c_done[k] = bus.done;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req = '0;
    bus.code = '0;
    bus.main_program = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic start(input logic [3:0] m, input logic [15:0] c);
    bus.req = m;
    bus.code = c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.code = '0; bus.main_program = 1'b1;
    #1;
    checks++;
    if ({bus.led, bus.grant, bus.done, bus.busy} !== 10'd0) begin
      failures++; $display("FAIL reset_vals got led=%b grant=%b done=%b busy=%b want all 0", bus.led, bus.grant, bus.done, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.main_program = 1'b0;
    bus.req = 4'b0001;
    bus.code = 16'h0003;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.led, bus.grant, bus.busy} !== 6'd0) begin
        failures++; $display("FAIL disabled_idle got led=%b grant=%b busy=%b want 0", bus.led, bus.grant, bus.busy);
      end
    end
  endtask

  task automatic test_single();
    reset_dut();
    start(4'b0001, 16'h0003);
    bus.req = '0;
    capture(0, 225);
    model(4'b0001, 16'h0003, 1'b1, 225, 3);
    for (int k = 0; k < 225; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL single k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    start(4'b0011, 16'h0011);
    capture(0, 363);
    model(4'b0011, 16'h0011, 1'b0, 363, 3);
    for (int k = 0; k < 363; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL rr k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
    reset_dut();
    start(4'b1001, 16'h2002);
    checks++;
    if (bus.grant !== 4'b0001) begin
      failures++; $display("FAIL rr_first got grant=%b want 0001", bus.grant);
    end
  endtask

  task automatic test_zero_code();
    reset_dut();
    start(4'b0100, 16'h0000);
    bus.req = '0;
    capture(0, 105);
    model(4'b0100, 16'h0000, 1'b1, 105, 3);
    for (int k = 0; k < 105; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL zero k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
  endtask

  task automatic test_abort();
    reset_dut();
    start(4'b0001, 16'h0003);
    capture(0, 55);
    model(4'b0001, 16'h0003, 1'b1, 55, 3);
    for (int k = 0; k < 55; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL abort_pre k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
    bus.main_program = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.led, bus.grant, bus.done, bus.busy} !== 10'd0) begin
        failures++; $display("FAIL abort got led=%b grant=%b done=%b busy=%b want all 0", bus.led, bus.grant, bus.done, bus.busy);
      end
    end
    bus.main_program = 1'b1;
    @(posedge clk); #1;
    capture(0, 225);
    model(4'b0001, 16'h0003, 1'b0, 225, 0);
    for (int k = 0; k < 225; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL abort_restart k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    start(4'b0001, 16'h0003);
    capture(0, 180);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.led, bus.grant, bus.busy, bus.done} !== 10'd0) begin
      failures++; $display("FAIL async_rst got led=%b grant=%b busy=%b done=%b want all 0", bus.led, bus.grant, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.done, bus.grant} !== 8'd0) begin
      failures++; $display("FAIL async_rst_hold got done=%b grant=%b want 0", bus.done, bus.grant);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    capture(0, 50);
    model(4'b0001, 16'h0003, 1'b1, 50, 3);
    for (int k = 0; k < 50; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL async_restart k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
  endtask

  task automatic test_withdraw_change();
    reset_dut();
    start(4'b0010, 16'h0040);
    bus.req = '0;
    capture(0, 40);
    bus.code[7:4] = 4'd1;
    capture(40, 275);
    model(4'b0010, 16'h0040, 1'b1, 275, 3);
    for (int k = 0; k < 275; k++) begin
      checks++;
      if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
        failures++; $display("FAIL withdraw k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  m;
    logic [15:0] c;
    for (int it = 0; it < 4; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) c[4*r +: 4] = 4'($urandom_range(0, 3));
      reset_dut();
      start(m, c);
      capture(0, 700);
      model(m, c, 1'b0, 700, 3);
      for (int k = 0; k < 700; k++) begin
        checks++;
        if ({c_led[k], c_grant[k], c_done[k], c_busy[k]} !== {e_led[k], e_grant[k], e_done[k], e_busy[k]}) begin
          failures++; $display("FAIL random it=%0d req=%b code=%h k=%0d got led/grant/done/busy %b/%b/%b/%b want %b/%b/%b/%b", it, m, c, k, c_led[k], c_grant[k], c_done[k], c_busy[k], e_led[k], e_grant[k], e_done[k], e_busy[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_code();
    test_abort();
    test_async_reset();
    test_withdraw_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
